// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a ROWS x COLS matrix keypad plus NUM_OPS direct operation pins,
//   debounces press and release over whole scan frames, and queues one code
//   per confirmed key release in a small FIFO with a valid/ready handshake.
//
//   Code format (CODE_W bits):
//     number key : {1'b0, row*COLS + col}
//     op pin     : {1'b1, op_index}
//
//   Optional feature (compile-time macro KEY_REPEAT_EN):
//     While a number key stays held, its code is re-queued every REPEAT_SCANS
//     frames. Without the macro no repeat logic exists and REPEAT_SCANS only
//     takes part in the parameter legality check.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   o_word_lines  one-hot row drive, advances every cycle
//   i_bit_lines   column sense for the driven row, 1 = pressed
//   i_op_pins     operation buttons, 1 = pressed
//   o_data        FIFO head code
//   o_valid       FIFO non-empty
//   i_ready       consumer accepts the head code
//   o_fifo_count  FIFO occupancy
//   o_overflow    sticky flag: a code was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int NUM_OPS        = 6,
    parameter int CODE_W         = 5,
    parameter int DEBOUNCE_SCANS = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_SCANS   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [ROWS-1:0]               o_word_lines,
    input  logic [COLS-1:0]               i_bit_lines,
    input  logic [NUM_OPS-1:0]            i_op_pins,
    output logic [CODE_W-1:0]             o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow
);

    localparam int              IDX_W = CODE_W - 1;
    localparam int              RW    = $clog2(ROWS);
    localparam int              PW    = $clog2(FIFO_DEPTH);
    localparam int              CW    = PW + 1;
    localparam logic [3:0]      DEB   = 4'(DEBOUNCE_SCANS);
    localparam logic [ROWS-1:0] ROW0  = {{(ROWS-1){1'b0}}, 1'b1};

    if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 ||
        NUM_OPS < 1 || NUM_OPS > 16 ||
        ROWS * COLS > 2 ** (CODE_W - 1) || NUM_OPS > 2 ** (CODE_W - 1) ||
        DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        REPEAT_SCANS < 1) begin : g_param_check
        $error("keypad_scanner: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, PRESS_CONF, HELD, REL_CONF} state_t;

    // ---------------------------------------------------------------- scan
    logic [RW-1:0] row;
    logic          frame_end;

    assign frame_end    = (row == RW'(ROWS - 1));
    assign o_word_lines = ROW0 << row;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         row <= '0;
        else if (frame_end) row <= '0;
        else                row <= row + 1'b1;
    end

    // Sample of the currently driven row: highest pressed column wins.
    logic             col_hit;
    logic [IDX_W-1:0] col_idx;
    logic [IDX_W-1:0] num_now;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        col_hit = |i_bit_lines;
        col_idx = '0;
        for (int c = 0; c < COLS; c++)
            if (i_bit_lines[c]) col_idx = IDX_W'(c);
    end

    assign num_now = IDX_W'(row) * IDX_W'(COLS) + col_idx;

    // Frame accumulators; the f_* values fold in the current sample so the
    // frame result is complete in the r = ROWS-1 cycle.
    logic             acc_num_hit, f_num_hit;
    logic [IDX_W-1:0] acc_num_idx, f_num_idx;
    logic [NUM_OPS-1:0] acc_ops, f_ops;
    logic [IDX_W-1:0] op_idx;
    logic             f_op_any;
    logic             frame_pressed;
    logic [CODE_W-1:0] frame_code;

    assign f_num_hit = acc_num_hit | col_hit;
    assign f_num_idx = col_hit ? num_now : acc_num_idx;   // later row wins
    assign f_ops     = acc_ops | i_op_pins;
    assign f_op_any  = |f_ops;

    always_comb begin
        op_idx = '0;
        for (int i = NUM_OPS - 1; i >= 0; i--)
            if (f_ops[i]) op_idx = IDX_W'(i);             // lowest pin wins
    end

    assign frame_pressed = f_num_hit | f_op_any;
    assign frame_code    = f_op_any ? {1'b1, op_idx} : {1'b0, f_num_idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_num_hit <= 1'b0;
            acc_num_idx <= '0;
            acc_ops     <= '0;
        end else if (frame_end) begin
            acc_num_hit <= 1'b0;
            acc_num_idx <= '0;
            acc_ops     <= '0;
        end else begin
            acc_num_hit <= f_num_hit;
            acc_num_idx <= f_num_idx;
            acc_ops     <= f_ops;
        end
    end

    // ------------------------------------------------------ debounce FSM
    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next, cnt_inc;
    logic [CODE_W-1:0] cand;
    logic              load_cand;
    logic              fsm_push;
    logic              rep_push;
    logic              push_req;

    assign cnt_inc = cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (frame_end) begin
            unique case (state)
                IDLE:       if (frame_pressed)
                                state_next = (DEB == 4'd1) ? HELD : PRESS_CONF;
                PRESS_CONF: if (frame_pressed && frame_code == cand) begin
                                if (cnt_inc == DEB) state_next = HELD;
                            end else begin
                                state_next = IDLE;
                            end
                HELD:       if (!frame_pressed)
                                state_next = (DEB == 4'd1) ? IDLE : REL_CONF;
                REL_CONF:   if (frame_pressed)       state_next = HELD;
                            else if (cnt_inc == DEB) state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        load_cand = 1'b0;
        fsm_push  = 1'b0;
        cnt_next  = cnt;
        if (frame_end) begin
            unique case (state)
                IDLE:       if (frame_pressed) begin
                                load_cand = 1'b1;
                                cnt_next  = 4'd1;
                            end
                PRESS_CONF: if (frame_pressed && frame_code == cand)
                                cnt_next = cnt_inc;
                HELD:       if (!frame_pressed) begin
                                cnt_next = 4'd1;
                                fsm_push = (DEB == 4'd1);
                            end
                REL_CONF:   if (!frame_pressed) begin
                                cnt_next = cnt_inc;
                                fsm_push = (cnt_inc == DEB);
                            end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            cand <= '0;
        end else begin
            cnt <= cnt_next;
            if (load_cand) cand <= frame_code;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int               REP_W   = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_SCANS);

    logic [REP_W-1:0] rep, rep_next;

    // Counts held frames; cleared whenever HELD is (re)entered.
    always_comb begin
        rep_next = rep;
        rep_push = 1'b0;
        if (frame_end) begin
            if (state == HELD && frame_pressed) begin
                if (rep + 1'b1 == REP_MAX) begin
                    rep_next = '0;
                    rep_push = ~cand[CODE_W-1];         // op codes never repeat
                end else begin
                    rep_next = rep + 1'b1;
                end
            end else if (state != HELD && state_next == HELD) begin
                rep_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep <= '0;
        else        rep <= rep_next;
    end
`else
    assign rep_push = 1'b0;
`endif

    assign push_req = fsm_push | rep_push;

    // ---------------------------------------------------------------- FIFO
    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, do_pop, do_push;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign o_valid = (count != '0);
    assign do_pop  = o_valid & i_ready;
    // When full, a same-edge pop frees the slot being written (wr_ptr == rd_ptr).
    assign do_push = push_req & (~full | do_pop);

    // NOTE: the queue storage is reset along with the pointers so o_data reads
    // zero out of reset; it is only a handful of flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= cand;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
            if (push_req && full && !do_pop) o_overflow <= 1'b1;
        end
    end

    assign o_data       = mem[rd_ptr];
    assign o_fifo_count = count;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised successor to the fixed 4x4 calculator button reader.
- Scans a ROWS x COLS matrix keypad plus NUM_OPS direct operation pins, and debounces press and release over whole scan frames.
- Each confirmed key release is queued as a code in an output FIFO with a valid/ready handshake.
- Sits between the pad pins and the calculator control FSM.

Parameters:
- ROWS, 4: word lines driven; 2..8.
- COLS, 4: bit lines sampled; 2..8.
- NUM_OPS, 6: direct operation pins; 1..16.
- CODE_W, 5: output code width. Requires ROWS*COLS <= 2**(CODE_W-1) and NUM_OPS <= 2**(CODE_W-1).
- DEBOUNCE_SCANS, 2: consecutive frames needed to confirm a press or a release; 1..15.
- FIFO_DEPTH, 4: code queue entries; power of two, >= 2.
- REPEAT_SCANS, 8: auto-repeat period in frames; used only with KEY_REPEAT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- o_word_lines  out  ROWS  one-hot row drive
- i_bit_lines  in  COLS  column sense; 1 = pressed
- i_op_pins  in  NUM_OPS  operation buttons; 1 = pressed
- o_data  out  CODE_W  FIFO head code
- o_valid  out  1  FIFO non-empty
- i_ready  in  1  consumer accepts head
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- o_overflow  out  1  sticky: a code was dropped

Behaviour:
Reset:
- Asynchronous, active-low; all state is cleared.
- Outputs after reset: o_word_lines = 1, o_data = 0, o_valid = 0, o_fifo_count = 0, o_overflow = 0.
- FSM enters IDLE. A reset mid-scan or mid-debounce discards the candidate code and all queued codes.

Scanning:
- Row counter r runs 0..ROWS-1 and wraps, advancing every cycle.
- o_word_lines = 1<<r.
- i_bit_lines and i_op_pins are sampled in the same cycle as the row that is driven.
- One frame = ROWS cycles. The frame ends at the edge that closes the r = ROWS-1 cycle.

Frame result (accumulated across the frame, including the final sample):
- frame_pressed = any bit line or op pin high during the frame.
- Number code = {0, r*COLS + c}, where c is the highest set bit-line index. If several rows are pressed, the last-scanned pressed row wins.
- Op code = {1, i}, where i is the lowest set op-pin index.
- Any op pin overrides number codes for the whole frame.

Debounce FSM (updates only at the end of a frame; cnt is 4 bits):
- IDLE: if frame_pressed, cand = frame_code and cnt = 1. Go to HELD if DEBOUNCE_SCANS == 1, otherwise go to PRESS_CONF.
- PRESS_CONF:
  - If frame_pressed and frame_code == cand: cnt++. When cnt reaches DEBOUNCE_SCANS, go to HELD.
  - Otherwise (released or code changed): go to IDLE and drop cand.
- HELD:
  - Changes of code while held are ignored.
  - If !frame_pressed: cnt = 1. Go to IDLE and push cand if DEBOUNCE_SCANS == 1, otherwise go to REL_CONF.
- REL_CONF:
  - If frame_pressed: go back to HELD.
  - Otherwise cnt++. When cnt reaches DEBOUNCE_SCANS, push cand and go to IDLE.

FIFO:
- Push happens at the frame-end edge. o_valid is high from that edge; latency from the final release-frame edge to o_valid = 0 cycles (registered).
- Pop occurs when o_valid && i_ready; o_data advances at the same edge.
- Codes leave in push order.
- Push while full without a same-cycle pop: the code is dropped and o_overflow is set until reset.
- Push while full with a same-cycle pop: the push is accepted and the count is unchanged.
- Push and pop when not full: the count is unchanged.
- Pop when empty: ignored.
- Read/write pointers wrap modulo FIFO_DEPTH.
- o_data holds its value while o_valid = 0 and i_ready = 1.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts frames and is cleared on entry to HELD.
  - Each time it reaches REPEAT_SCANS, cand is pushed (if it is a number code) and the counter clears.
  - Op codes never repeat.
  - The push on release still occurs.
- Undefined: no repeat logic is built and REPEAT_SCANS is unused. Exactly one push occurs per press/release.

Test Plan:
1. Hold rst_n low, then release it -> o_word_lines = 0001, o_valid = 0, o_fifo_count = 0, o_overflow = 0; the row cycles 0001, 0010, 0100, 1000, 0001.
2. Press row 2 / col 1 for 4 frames, then release for 3 frames -> exactly one entry, o_data = 5'b01001, o_valid rises at the end of release frame 2.
3. Bit-line pulse lasting one frame only -> no push, FSM returns to IDLE, o_valid stays 0.
4. Op pin 3 held together with row 0 / col 0 for 3 frames, then released -> one code, 5'b10011.
5. i_ready = 0, press keys 1..5 in sequence -> o_fifo_count = 4 and o_overflow = 1. Then i_ready = 1 -> codes 1, 2, 3, 4 pop in order, and o_valid falls after the 4th pop.
6. KEY_REPEAT_EN, REPEAT_SCANS = 8: hold key 0 for 20 frames, then release -> three pushes of 5'b00000 (repeats at frames 10 and 18, plus the release push); holding op 0 gives one push only.
